// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and GF(2^8) helpers
// used by the iterative inverse-cipher core.
package aes_pkg;

  localparam int NR = 10;
  localparam int BLK_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEXP,
    ST_INIT,
    ST_ROUND,
    ST_DONE
  } state_t;

  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // Byte 0x00 sits in the top byte, hence the ~b index below.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] fwd_key(
    input logic [127:0] k,
    input logic [7:0]   rc
  );
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] inv_key(
    input logic [127:0] k,
    input logic [7:0]   rc
  );
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [7:0] m9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] mb(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] md(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] me(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {
        me(a0) ^ mb(a1) ^ md(a2) ^ m9(a3),
        m9(a0) ^ me(a1) ^ mb(a2) ^ md(a3),
        md(a0) ^ m9(a1) ^ me(a2) ^ mb(a3),
        mb(a0) ^ md(a1) ^ m9(a2) ^ me(a3)
      };
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box: one byte in, one byte out, pure lookup.
// Sixteen copies form the InvSubBytes layer of the round.
module aes_inv_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_y
);

  localparam logic [2047:0] INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign o_y = INV[{~i_a, 3'b000} +: 8];

endmodule

// File: rtl/aes128_decrypt.sv
// Iterative AES-128 inverse cipher, one round per clock; the key is
// expanded forward to rk10 and then unwound one round key per round.
module aes128_decrypt
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] ciphertext,
  input  logic [BLK_W-1:0] cipher_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] plaintext,
  output logic             busy
);

  state_t           r_state;
  logic [3:0]       r_rnd;
  logic [BLK_W-1:0] r_blk;
  logic [BLK_W-1:0] r_kreg;
  logic [BLK_W-1:0] r_pt;
  logic             r_out_valid;
  logic             r_in_ready;
  logic             r_busy;

  logic [BLK_W-1:0] w_fwd;
  logic [BLK_W-1:0] w_rk_prev;
  logic [BLK_W-1:0] w_isr;
  logic [BLK_W-1:0] w_isb;
  logic [BLK_W-1:0] w_t;
  logic [BLK_W-1:0] w_imc;

  assign w_fwd     = fwd_key(r_kreg, RCON[r_rnd]);
  assign w_rk_prev = inv_key(r_kreg, RCON[r_rnd]);
  assign w_isr     = inv_shift_rows(r_blk);

  for (genvar g = 0; g < 16; g++) begin : g_isb
    aes_inv_sbox u_isb (
      .i_a (w_isr[8*g +: 8]),
      .o_y (w_isb[8*g +: 8])
    );
  end

  assign w_t   = w_isb ^ w_rk_prev;
  assign w_imc = inv_mix_columns(w_t);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rnd       <= '0;
      r_blk       <= '0;
      r_kreg      <= '0;
      r_pt        <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_blk      <= ciphertext;
            r_kreg     <= cipher_key;
            r_rnd      <= 4'd1;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_KEXP;
          end
        end
        ST_KEXP: begin
          r_kreg <= w_fwd;
          r_rnd  <= r_rnd + 4'd1;
          if (r_rnd == 4'(NR)) r_state <= ST_INIT;
        end
        ST_INIT: begin
          r_blk   <= r_blk ^ r_kreg;
          r_rnd   <= 4'(NR);
          r_state <= ST_ROUND;
        end
        ST_ROUND: begin
          r_kreg <= w_rk_prev;
          r_rnd  <= r_rnd - 4'd1;
          // The final round has no InvMixColumns.
          if (r_rnd == 4'd1) begin
            r_blk       <= w_t;
            r_pt        <= w_t;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_blk <= w_imc;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign plaintext = r_pt;

endmodule

// File: tb/tb_aes128_decrypt.sv
// Directed and round-trip checks for the iterative AES-128 decryptor
// against FIPS-197 vectors and a local encryption model.
module tb_aes128_decrypt;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] ct = '0;
  logic [127:0] key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] plaintext;
  logic         busy;

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  localparam logic [2047:0] SB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  aes128_decrypt dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ct),
    .cipher_key (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SB[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] kstep(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sb(k[23:16]), sb(k[15:8]), sb(k[7:0]), sb(k[31:24])} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] ref_enc(input logic [127:0] k0, input logic [127:0] p);
    logic [127:0] s, k, u;
    logic [7:0] rc, a0, a1, a2, a3;
    s  = p ^ k0;
    k  = k0;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      k  = kstep(k, rc);
      rc = xt(rc);
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = sb(s[127-8*i -: 8]);
      u = s;
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          s[127-8*(q+4*c) -: 8] = u[127-8*(q+4*((c+q)%4)) -: 8];
      if (r != 10)
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8];
          a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8];
          a3 = s[103-32*c -: 8];
          s[127-32*c -: 32] = {
            xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)
          };
        end
      s = s ^ k;
    end
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // Waits for in_ready, accepts one block, then counts cycles to out_valid.
  task automatic launch(input logic [127:0] k, input logic [127:0] c,
                        output int lat);
    bit acc;
    acc = 0;
    lat = -1;
    key = k;
    ct = c;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        step();
        acc = 1;
        break;
      end
      step();
    end
    in_valid = 1'b0;
    if (acc)
      for (int n = 1; n <= 40; n++) begin
        step();
        if (out_valid) begin
          lat = n;
          break;
        end
      end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
    checks++;
    if (out_valid !== 1'b0 || plaintext !== '0) begin
      failures++;
      $display("FAIL reset_out: out_valid=%b pt=%h want 0 0", out_valid, plaintext);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_fips_c1();
    int lat;
    launch(C1_KEY, C1_CT, lat);
    checks++;
    if (lat != 21) begin
      failures++;
      $display("FAIL c1_latency: got %0d want 21", lat);
    end
    checks++;
    if (plaintext !== C1_PT) begin
      failures++;
      $display("FAIL c1_pt: got %h want %h", plaintext, C1_PT);
    end
    checks++;
    if (dut.r_kreg !== C1_KEY) begin
      failures++;
      $display("FAIL c1_rk0: got %h want %h", dut.r_kreg, C1_KEY);
    end
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL c1_done_flags: busy=%b in_ready=%b want 1 0", busy, in_ready);
    end
    drain();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL c1_consume: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_fips_b();
    int n;
    key = B_KEY;
    ct = B_CT;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    checks++;
    if (dut.r_kreg !== B_RK10) begin
      failures++;
      $display("FAIL b_rk10: got %h want %h", dut.r_kreg, B_RK10);
    end
    n = 10;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (n != 21) begin
      failures++;
      $display("FAIL b_latency: got %0d want 21", n);
    end
    checks++;
    if (plaintext !== B_PT) begin
      failures++;
      $display("FAIL b_pt: got %h want %h", plaintext, B_PT);
    end
    drain();
  endtask

  task automatic test_back_pressure();
    int lat;
    launch(C1_KEY, C1_CT, lat);
    checks++;
    if (lat != 21 || plaintext !== C1_PT) begin
      failures++;
      $display("FAIL bp_first: lat=%0d pt=%h want 21 %h", lat, plaintext, C1_PT);
    end
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      key = {$urandom, $urandom, $urandom, $urandom};
      ct = {$urandom, $urandom, $urandom, $urandom};
      step();
      checks++;
      if (plaintext !== C1_PT || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold[%0d]: pt=%h rdy=%b ov=%b want %h 0 1",
                 i, plaintext, in_ready, out_valid, C1_PT);
      end
    end
    key = B_KEY;
    ct = B_CT;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_simul: ov=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_accept: busy=%b rdy=%b want 1 0", busy, in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    checks++;
    if (lat != 21 || plaintext !== B_PT) begin
      failures++;
      $display("FAIL bp_second: lat=%0d pt=%h want 21 %h", lat, plaintext, B_PT);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int n;
    key = B_KEY;
    ct = B_CT;
    in_valid = 1'b1;
    step();
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n != 21 || plaintext !== B_PT) begin
      failures++;
      $display("FAIL b2b_first: lat=%0d pt=%h want 21 %h", n, plaintext, B_PT);
    end
    key = C1_KEY;
    ct = C1_CT;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: rdy=%b ov=%b want 1 0", in_ready, out_valid);
    end
    step();
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept: busy=%b rdy=%b want 1 0", busy, in_ready);
    end
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n != 21 || plaintext !== C1_PT) begin
      failures++;
      $display("FAIL b2b_second: lat=%0d pt=%h want 21 %h", n, plaintext, C1_PT);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int lat;
    key = C1_KEY;
    ct = C1_CT;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (16) step();
    checks++;
    if (dut.r_rnd !== 4'd5 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_position: rnd=%0d busy=%b want 5 1", dut.r_rnd, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || plaintext !== '0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_abort: ov=%b pt=%h rdy=%b busy=%b want 0 0 1 0",
               out_valid, plaintext, in_ready, busy);
    end
    #2;
    rst_n = 1'b1;
    step();
    launch(C1_KEY, C1_CT, lat);
    checks++;
    if (lat != 21 || plaintext !== C1_PT) begin
      failures++;
      $display("FAIL mid_recover: lat=%0d pt=%h want 21 %h", lat, plaintext, C1_PT);
    end
    drain();
  endtask

  task automatic test_random();
    logic [127:0] k, p, c;
    int lat;
    for (int i = 0; i < 500; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      c = ref_enc(k, p);
      launch(k, c, lat);
      checks++;
      if (lat != 21 || plaintext !== p || dut.r_kreg !== k) begin
        failures++;
        $display("FAIL rand[%0d]: lat=%0d pt=%h want %h", i, lat, plaintext, p);
      end
      drain();
    end
  endtask

  initial begin
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
